program_sequencer: RTL and testbench
====================================

Name: program_sequencer

Overview:
- Parametrised successor to the pico_mips program counter; drives the instruction-ROM address.
- Keeps increment, absolute branch and switch-qualified hold.
- Adds PC-relative branch, pipeline stall, and a hardware call/return stack with full/empty status and a sticky error flag.
- Sits between the decoder (control strobes, branch target/offset) and the program ROM.

Parameters:
PC_W, 5, PC and address width in bits (range 2..16)
DEPTH, 4, return-stack entries (power of two, at least 2)
RESET_VECTOR, 0, PC value loaded on reset (PC_W bits)

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
stall  input  1  freeze all state this cycle
bran  input  1  absolute jump to target
rel  input  1  relative branch, pc <= pc + offset
call  input  1  push pc+1, jump to target
ret  input  1  pop stack into pc
is_hold  input  1  conditional hold instruction
sw  input  1  external switch input (sw8)
condition  input  1  value sw must equal to release a hold
target  input  PC_W  absolute branch/call target
offset  input  PC_W  two's-complement branch offset
pc  output  PC_W  current program counter
sp  output  $clog2(DEPTH)+1  number of valid stack entries
stack_full  output  1  sp == DEPTH
stack_empty  output  1  sp == 0
err  output  1  sticky overflow/underflow flag

Behaviour:
- Reset (async, any time, including mid-call): pc=RESET_VECTOR, sp=0, err=0, stack contents don't-care. Outputs valid as soon as Reset asserts.
- One action per rising edge, selected by fixed priority: stall > ret > call > bran > rel > is_hold > increment. Lower-priority strobes asserted in the same cycle are ignored with no side effects.
- stall: pc, sp, stack and err all unchanged.
- ret, sp>0: pc <= stack[sp-1]; sp <= sp-1.
- ret, sp==0 (underflow): pc <= pc+1; err <= 1; sp stays 0.
- call, sp<DEPTH: stack[sp] <= pc+1; sp <= sp+1; pc <= target.
- call, sp==DEPTH (overflow): pc <= target; push suppressed; sp unchanged; err <= 1. The existing stack is not corrupted.
- bran: pc <= target.
- rel: pc <= pc + offset, modulo 2^PC_W. The offset is signed, so an all-ones offset yields pc-1.
- is_hold: pc <= pc+1 if sw==condition, else pc unchanged. Re-evaluated every cycle the hold is presented.
- Default: pc <= pc+1.
- Arithmetic: all pc arithmetic is PC_W bits and wraps silently. 2^PC_W-1 +1 gives 0. Wrap does not set err.
- Return address: the pushed value is pc+1 wrapped, so a call at the top address pushes 0.
- err: sticky; cleared only by Reset.
- Status flags: stack_full and stack_empty are combinational from the sp register only, with no input-to-output path.
- Timing: single-cycle latency; the new pc is visible the cycle after the strobe. No handshake. Strobes are level-sampled every edge; a strobe held for N cycles acts N times.
- Stack storage: register array DEPTH x PC_W, no reset required. sp is fully reset.

Test Plan:
- Reset and increment (PC_W=5, RESET_VECTOR=0): Reset pulse, then 33 free-running cycles -> pc counts 0..31, wraps to 0 and then 1; err=0 throughout.
- Hold: at pc=3 drive is_hold=1, condition=1, sw=0 for 4 cycles, then sw=1 -> pc stays 3 for 4 cycles, then 4. Raising stall for 2 cycles at pc=6 -> pc stays 6.
- Branches: at pc=10, bran with target=2 -> pc=2. At pc=2, rel with offset=5'b11110 -> pc=0. At pc=30, rel with offset=3 -> pc=1.
- Nested calls: from pc=1, call with target=20; then at pc=20, call with target=25 -> sp=2, stack holds {2,21}. Then ret -> pc=21, sp=1; ret -> pc=2, sp=0, stack_empty=1.
- Overflow/underflow (DEPTH=4): 5 consecutive calls with target=8 -> stack_full=1 after the 4th, 5th call jumps to 8 with sp=4 and err=1. 4 rets return the correct addresses; a 5th ret -> pc+1, sp=0. Only Reset clears err.
- Priority and async reset: call, ret and bran asserted together with sp=1 -> only the pop occurs. Assert Reset mid-cycle with sp=3 -> pc=0, sp=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/program_sequencer_if.sv
// Decoder-to-sequencer bus: control strobes and branch operands in, PC and
// return-stack status out.
interface program_sequencer_if #(
  parameter int PC_W  = 5,
  parameter int DEPTH = 4
);
  localparam int SP_W = $clog2(DEPTH) + 1;

  logic                   stall;
  logic                   bran;
  logic                   rel;
  logic                   call;
  logic                   ret;
  logic                   is_hold;
  logic                   sw;
  logic                   condition;
  logic        [PC_W-1:0] target;
  logic signed [PC_W-1:0] offset;
  logic        [PC_W-1:0] pc;
  logic        [SP_W-1:0] sp;
  logic                   stack_full;
  logic                   stack_empty;
  logic                   err;

  modport master (
    output stall, bran, rel, call, ret, is_hold, sw, condition, target, offset,
    input  pc, sp, stack_full, stack_empty, err
  );

  modport slave (
    input  stall, bran, rel, call, ret, is_hold, sw, condition, target, offset,
    output pc, sp, stack_full, stack_empty, err
  );
endinterface

// File: rtl/program_sequencer.sv
// Instruction-ROM address generator: increment, absolute/relative branch,
// switch-qualified hold, stall, and a call/return stack with sticky error.
module program_sequencer #(
  parameter int                PC_W         = 5,
  parameter int                DEPTH        = 4,
  parameter logic [PC_W-1:0]   RESET_VECTOR = '0
) (
  input logic               Clock,
  input logic               Reset,
  program_sequencer_if.slave bus
);
  localparam int SP_W = $clog2(DEPTH) + 1;
  localparam int AW   = $clog2(DEPTH);
  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);
  localparam logic [SP_W-1:0] SP_ONE = SP_W'(1);
  localparam logic [SP_W-1:0] SP_MAX = SP_W'(DEPTH);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [SP_W-1:0] sp_q, sp_d;
  logic            err_q, err_d;
  logic [PC_W-1:0] stack_q [DEPTH];

  logic            push_en;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_rel;
  logic [SP_W-1:0] sp_m1;
  logic [AW-1:0]   push_idx;
  logic [AW-1:0]   pop_idx;
  logic            full, empty;

  // Two's-complement add that wraps silently at PC_W bits.
  function automatic logic [PC_W-1:0] wrap_add(input logic [PC_W-1:0] a,
                                               input logic signed [PC_W-1:0] b);
    return a + $unsigned(b);
  endfunction

  assign pc_inc   = pc_q + PC_ONE;
  assign pc_rel   = wrap_add(pc_q, bus.offset);
  assign sp_m1    = sp_q - SP_ONE;
  assign push_idx = sp_q[AW-1:0];
  assign pop_idx  = sp_m1[AW-1:0];
  assign full     = (sp_q == SP_MAX);
  assign empty    = (sp_q == '0);

  always_comb begin
    pc_d    = pc_q;
    sp_d    = sp_q;
    err_d   = err_q;
    push_en = 1'b0;
    if (!bus.stall) begin
      if (bus.ret) begin
        if (empty) begin
          pc_d  = pc_inc;
          err_d = 1'b1;
        end else begin
          pc_d = stack_q[pop_idx];
          sp_d = sp_m1;
        end
      end else if (bus.call) begin
        // Overflowing call still jumps; only the push is dropped.
        pc_d = bus.target;
        if (full) begin
          err_d = 1'b1;
        end else begin
          push_en = 1'b1;
          sp_d    = sp_q + SP_ONE;
        end
      end else if (bus.bran) begin
        pc_d = bus.target;
      end else if (bus.rel) begin
        pc_d = pc_rel;
      end else if (bus.is_hold) begin
        if (bus.sw == bus.condition) pc_d = pc_inc;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pc_q  <= RESET_VECTOR;
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  // Stack contents are don't-care after reset; only sp qualifies them.
  always_ff @(posedge Clock) begin
    if (push_en) stack_q[push_idx] <= pc_inc;
  end

  assign bus.pc          = pc_q;
  assign bus.sp          = sp_q;
  assign bus.err         = err_q;
  assign bus.stack_full  = full;
  assign bus.stack_empty = empty;
endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer with PC_W=5, DEPTH=4, RESET_VECTOR=0.
module tb_program_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  program_sequencer_if #(.PC_W(5), .DEPTH(4)) bus ();

  program_sequencer #(.PC_W(5), .DEPTH(4), .RESET_VECTOR(5'd0)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.stall = 0; bus.bran = 0; bus.rel = 0; bus.call = 0; bus.ret = 0;
    bus.is_hold = 0; bus.sw = 0; bus.condition = 0; bus.target = '0; bus.offset = '0;
  endtask

  initial begin
    clr();
    #3;
    chk("rst_pc", bus.pc, 0);
    chk("rst_sp", bus.sp, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_empty", bus.stack_empty, 1);
    chk("rst_full", bus.stack_full, 0);
    tick();
    rst = 1'b0;

    // free-running increment with wrap
    for (int i = 0; i < 33; i++) begin
      tick();
      chk("inc_pc", bus.pc, (i + 1) % 32);
      chk("inc_err", bus.err, 0);
    end
    tick(); tick();
    chk("pre_hold_pc", bus.pc, 3);

    // hold until sw matches condition
    bus.is_hold = 1; bus.condition = 1; bus.sw = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold_pc", bus.pc, 3);
    end
    bus.sw = 1;
    tick();
    chk("hold_release", bus.pc, 4);
    clr();
    tick(); tick();
    chk("pre_stall_pc", bus.pc, 6);
    bus.stall = 1; bus.call = 1; bus.target = 5'd17;
    tick(); chk("stall_pc", bus.pc, 6);
    tick(); chk("stall_pc2", bus.pc, 6);
    chk("stall_sp", bus.sp, 0);
    clr();

    // branches
    repeat (4) tick();
    chk("pre_bran_pc", bus.pc, 10);
    bus.bran = 1; bus.target = 5'd2;
    tick(); chk("bran_pc", bus.pc, 2);
    clr();
    bus.rel = 1; bus.offset = 5'b11110;
    tick(); chk("rel_neg", bus.pc, 0);
    clr();
    bus.bran = 1; bus.target = 5'd30;
    tick(); chk("bran30", bus.pc, 30);
    clr();
    bus.rel = 1; bus.offset = 5'd3;
    tick(); chk("rel_wrap", bus.pc, 1);
    clr();

    // nested calls and returns
    bus.call = 1; bus.target = 5'd20;
    tick(); chk("call1_pc", bus.pc, 20); chk("call1_sp", bus.sp, 1);
    bus.target = 5'd25;
    tick(); chk("call2_pc", bus.pc, 25); chk("call2_sp", bus.sp, 2);
    clr();
    bus.ret = 1;
    tick(); chk("ret1_pc", bus.pc, 21); chk("ret1_sp", bus.sp, 1);
    tick(); chk("ret2_pc", bus.pc, 2); chk("ret2_sp", bus.sp, 0);
    chk("ret2_empty", bus.stack_empty, 1);
    chk("nest_err", bus.err, 0);
    clr();

    // overflow: pushes 3,9,9,9 then a suppressed fifth push
    bus.call = 1; bus.target = 5'd8;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("ovf_pc", bus.pc, 8);
      chk("ovf_sp", bus.sp, i);
    end
    chk("ovf_full", bus.stack_full, 1);
    chk("ovf_err_pre", bus.err, 0);
    tick();
    chk("ovf5_pc", bus.pc, 8);
    chk("ovf5_sp", bus.sp, 4);
    chk("ovf5_err", bus.err, 1);
    clr();

    bus.ret = 1;
    tick(); chk("pop1_pc", bus.pc, 9); chk("pop1_sp", bus.sp, 3);
    tick(); chk("pop2_pc", bus.pc, 9); chk("pop2_sp", bus.sp, 2);
    tick(); chk("pop3_pc", bus.pc, 9); chk("pop3_sp", bus.sp, 1);
    tick(); chk("pop4_pc", bus.pc, 3); chk("pop4_sp", bus.sp, 0);
    tick(); chk("unf_pc", bus.pc, 4); chk("unf_sp", bus.sp, 0);
    chk("unf_err", bus.err, 1);
    clr();
    tick(); chk("sticky_pc", bus.pc, 5); chk("sticky_err", bus.err, 1);

    // priority: ret wins over call and bran
    bus.call = 1; bus.target = 5'd12;
    tick(); chk("pri_setup_pc", bus.pc, 12); chk("pri_setup_sp", bus.sp, 1);
    bus.ret = 1; bus.bran = 1; bus.target = 5'd17;
    tick(); chk("pri_pc", bus.pc, 6); chk("pri_sp", bus.sp, 0);
    chk("pri_empty", bus.stack_empty, 1);
    clr();

    // async reset mid-cycle with sp=3
    bus.call = 1; bus.target = 5'd8;
    repeat (3) tick();
    chk("ar_setup_sp", bus.sp, 3);
    clr();
    #2 rst = 1'b1;
    #1;
    chk("ar_pc", bus.pc, 0);
    chk("ar_sp", bus.sp, 0);
    chk("ar_err", bus.err, 0);
    #1 rst = 1'b0;
    tick(); chk("post_rst_pc", bus.pc, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
